// File: rtl/mem_arbiter.sv
// mem_arbiter: boot-phase sequencing and P1/P2 arbitration of the unified memory port with in-order read returns
module mem_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        loader_done,
  input  logic        p0_req,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p0_we,
  input  logic [1:0]  p0_size,
  input  logic        p1_req,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic        p1_we,
  input  logic [1:0]  p1_size,
  input  logic        p2_req,
  input  logic [31:0] p2_addr,
  input  logic [31:0] p2_wdata,
  input  logic        p2_we,
  input  logic [1:0]  p2_size,
  output logic        p0_gnt,
  output logic        p1_gnt,
  output logic        p2_gnt,
  output logic        p0_rvalid,
  output logic        p1_rvalid,
  output logic        p2_rvalid,
  output logic [31:0] rdata,
  output logic        misalign_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_write,
  output logic [1:0]  mem_access_size,
  input  logic [31:0] mem_data_out
);
  typedef enum logic {BOOT, RUN} state_t;
  localparam int LAST = READ_LATENCY - 1;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  state_t state, state_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic g0, g1, g2, any, mis;
  logic [31:0] s_addr, s_wdata, addr_q, wdata_q;
  logic [1:0] s_size, size_q;
  logic s_we;
  logic [READ_LATENCY-1:0] pv, pm;
  logic [READ_LATENCY-1:0][1:0] pid;
  // State and starvation counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end
  // Winner selection, next state and starvation count
  always_comb begin
    g0 = rst_n && state == BOOT && p0_req;
    g2 = rst_n && state == RUN && p2_req && (!p1_req || starve_cnt == LIM);
    g1 = rst_n && state == RUN && p1_req && !g2;
    any = g0 || g1 || g2;
    s_addr = g0 ? p0_addr : g1 ? p1_addr : p2_addr;
    s_wdata = g0 ? p0_wdata : g1 ? p1_wdata : p2_wdata;
    s_we = g0 ? p0_we : g1 ? p1_we : p2_we;
    s_size = g0 ? p0_size : g1 ? p1_size : p2_size;
    mis = s_size == 2'b01 ? s_addr[0] : s_size[1] ? |s_addr[1:0] : 1'b0;
    state_nxt = (state == BOOT && loader_done && !p0_req) ? RUN : state;
    starve_nxt = (state == RUN && p2_req && !g2) ? (starve_cnt == LIM ? starve_cnt : starve_cnt + 4'd1) : 4'd0;
  end
  // Hold last driven memory fields and shift the read-return pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      wdata_q <= '0;
      size_q <= '0;
      pv <= '0;
      pm <= '0;
      pid <= '0;
    end else begin
      if (any) begin
        addr_q <= s_addr;
        wdata_q <= s_wdata;
        size_q <= s_size;
      end
      for (int i = LAST; i > 0; i--) begin
        pv[i] <= pv[i-1];
        pm[i] <= pm[i-1];
        pid[i] <= pid[i-1];
      end
      pv[0] <= any && !s_we;
      pm[0] <= mis;
      pid[0] <= g0 ? 2'd0 : g1 ? 2'd1 : 2'd2;
    end
  end
  // Drive memory port, grants and read returns
  always_comb begin
    p0_gnt = g0;
    p1_gnt = g1;
    p2_gnt = g2;
    misalign_err = any && mis;
    mem_write = any && s_we && !mis;
    mem_address = any ? s_addr : addr_q;
    mem_data_in = any ? s_wdata : wdata_q;
    mem_access_size = any ? s_size : size_q;
    p0_rvalid = pv[LAST] && pid[LAST] == 2'd0;
    p1_rvalid = pv[LAST] && pid[LAST] == 2'd1;
    p2_rvalid = pv[LAST] && pid[LAST] == 2'd2;
    rdata = (pv[LAST] && !pm[LAST]) ? mem_data_out : 32'd0;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a behavioural model
module tb_mem_arbiter;
  localparam int L = 2;
  localparam int LIM = 4;
  logic clk = 0, rst_n = 0, loader_done = 0;
  logic [2:0] req, we, gnt, rv;
  logic [31:0] addr[3], wdata[3];
  logic [1:0] size[3];
  logic [31:0] rdata, mem_address, mem_data_in, mem_data_out;
  logic misalign_err, mem_write;
  logic [1:0] mem_access_size;
  logic [31:0] mem[16];
  logic [31:0] rd_pipe[L];
  int total = 0, bad = 0;
  typedef struct {int due; int port; bit mis; logic [31:0] data;} rd_t;
  rd_t q[$];
  bit m_boot = 1;
  int m_cnt = 0, cyc = 0;
  logic [31:0] h_addr = 0, h_wd = 0;
  logic [1:0] h_sz = 0;
  bit [2:0] en, g_seen;

  always #5 clk = ~clk;

  mem_arbiter #(.READ_LATENCY(L), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .loader_done(loader_done),
    .p0_req(req[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]), .p0_we(we[0]), .p0_size(size[0]),
    .p1_req(req[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]), .p1_we(we[1]), .p1_size(size[1]),
    .p2_req(req[2]), .p2_addr(addr[2]), .p2_wdata(wdata[2]), .p2_we(we[2]), .p2_size(size[2]),
    .p0_gnt(gnt[0]), .p1_gnt(gnt[1]), .p2_gnt(gnt[2]),
    .p0_rvalid(rv[0]), .p1_rvalid(rv[1]), .p2_rvalid(rv[2]),
    .rdata(rdata), .misalign_err(misalign_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_write(mem_write),
    .mem_access_size(mem_access_size), .mem_data_out(mem_data_out)
  );

  // memory with byte lanes and READ_LATENCY-cycle read data
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 0;
    end else if (mem_write) begin
      if (mem_access_size == 2'b00) mem[mem_address[5:2]][8*mem_address[1:0] +: 8] <= mem_data_in[7:0];
      else if (mem_access_size == 2'b01) mem[mem_address[5:2]][16*mem_address[1] +: 16] <= mem_data_in[15:0];
      else mem[mem_address[5:2]] <= mem_data_in;
    end
    rd_pipe[0] <= mem[mem_address[5:2]];
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_data_out = rd_pipe[L-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // model: expected outputs from the arbitration rules every cycle
  always @(negedge clk) begin : cmp
    int w;
    logic [31:0] a;
    bit mis;
    if (!rst_n) begin
      for (int n = 0; n < 3; n++) begin
        chk("rst_gnt", gnt[n], 0);
        chk("rst_rvalid", rv[n], 0);
      end
      chk("rst_misalign", misalign_err, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_mem_address", mem_address, 0);
      chk("rst_mem_data_in", mem_data_in, 0);
      chk("rst_size", mem_access_size, 0);
      chk("rst_rdata", rdata, 0);
      q.delete();
      m_boot = 1;
      m_cnt = 0;
      h_addr = 0;
      h_wd = 0;
      h_sz = 0;
    end else begin
      w = -1;
      mis = 0;
      a = 0;
      if (m_boot) begin
        if (req[0]) w = 0;
      end else if (req[2] && (!req[1] || m_cnt == LIM)) w = 2;
      else if (req[1]) w = 1;
      if (w >= 0) begin
        a = addr[w];
        mis = size[w] == 2'b01 ? a[0] : size[w][1] ? (a[1:0] != 0) : 1'b0;
      end
      for (int n = 0; n < 3; n++) chk("gnt", gnt[n], w == n);
      chk("misalign", misalign_err, w >= 0 && mis);
      chk("mem_write", mem_write, w >= 0 ? (we[w] && !mis) : 1'b0);
      chk("mem_address", mem_address, w >= 0 ? addr[w] : h_addr);
      chk("mem_data_in", mem_data_in, w >= 0 ? wdata[w] : h_wd);
      chk("mem_size", mem_access_size, w >= 0 ? size[w] : h_sz);
      for (int n = 0; n < 3; n++)
        chk("rvalid", rv[n], q.size() > 0 && q[0].due == cyc && q[0].port == n);
      if (q.size() > 0 && q[0].due == cyc) begin
        chk("rdata", rdata, q[0].mis ? 32'd0 : q[0].data);
        void'(q.pop_front());
      end
      if (w >= 0) begin
        h_addr = addr[w];
        h_wd = wdata[w];
        h_sz = size[w];
        if (!we[w]) q.push_back('{due: cyc + L, port: w, mis: mis, data: mem[a[5:2]]});
      end
      if (m_boot) m_cnt = 0;
      else m_cnt = (req[2] && w != 2) ? (m_cnt < LIM ? m_cnt + 1 : LIM) : 0;
      if (m_boot && loader_done && !req[0]) m_boot = 0;
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input int n, input logic [31:0] a, input logic [31:0] d, input bit w, input logic [1:0] s);
    req[n] = 1;
    addr[n] = a;
    wdata[n] = d;
    we[n] = w;
    size[n] = s;
  endtask

  task automatic rnd(input int n);
    set(n, 32'h80020000 | 32'($urandom_range(0, 63)), $urandom, 1'($urandom), 2'($urandom));
  endtask

  task automatic rnd_run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      g_seen = gnt;
      step();
      for (int n = 0; n < 3; n++)
        if (!en[n]) req[n] = 0;
        else if (!req[n] || g_seen[n]) begin
          if ($urandom_range(0, 3) != 0) rnd(n);
          else req[n] = 0;
        end
    end
  endtask

  initial begin
    req = 0;
    we = 0;
    for (int n = 0; n < 3; n++) begin
      addr[n] = 0;
      wdata[n] = 0;
      size[n] = 0;
    end
    repeat (3) step();
    rst_n = 1;
    // boot write of one byte
    set(0, 32'h80020000, 32'hA5, 1, 2'b00);
    @(negedge clk);
    chk("t1_p0_gnt", gnt[0], 1);
    chk("t1_mem_write", mem_write, 1);
    chk("t1_size", mem_access_size, 0);
    chk("t1_addr", mem_address, 32'h80020000);
    chk("t1_data", mem_data_in, 32'hA5);
    step();
    req[0] = 0;
    // P1/P2 ignored in BOOT, RUN after loader_done with p0 idle
    set(1, 32'h80020004, 0, 0, 2'b10);
    set(2, 32'h80020008, 0, 0, 2'b10);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t2_boot_p1", gnt[1], 0);
      chk("t2_boot_p2", gnt[2], 0);
      step();
    end
    req[2] = 0;
    loader_done = 1;
    @(negedge clk);
    chk("t2_transition_p1", gnt[1], 0);
    step();
    @(negedge clk);
    chk("t2_run_p1", gnt[1], 1);
    step();
    // continuous contention: four P1 wins then one forced P2 win
    set(1, 32'h80020010, 32'h11111111, 1, 2'b10);
    set(2, 32'h80020014, 32'h22222222, 1, 2'b10);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_p1", gnt[1], i % 5 != 4);
      chk("t3_p2", gnt[2], i % 5 == 4);
      step();
    end
    req = 0;
    // P2 aligned word read returns after READ_LATENCY
    set(2, 32'h80020000, 0, 0, 2'b10);
    @(negedge clk);
    chk("t4_gnt", gnt[2], 1);
    step();
    req[2] = 0;
    @(negedge clk);
    chk("t4_rv_early", rv[2], 0);
    step();
    @(negedge clk);
    chk("t4_rv", rv[2], 1);
    chk("t4_rdata", rdata, 32'h000000A5);
    step();
    @(negedge clk);
    chk("t4_rv_late", rv[2], 0);
    // misaligned write is suppressed, misaligned read returns zero
    set(1, 32'h80020002, 32'hDEADBEEF, 1, 2'b10);
    @(negedge clk);
    chk("t5_gnt", gnt[1], 1);
    chk("t5_misalign", misalign_err, 1);
    chk("t5_mem_write", mem_write, 0);
    step();
    req[1] = 0;
    @(negedge clk);
    chk("t5_mem_kept", mem[0], 32'h000000A5);
    set(1, 32'h80020001, 0, 0, 2'b01);
    @(negedge clk);
    chk("t5_half_misalign", misalign_err, 1);
    step();
    req[1] = 0;
    step();
    @(negedge clk);
    chk("t5_mis_rv", rv[1], 1);
    chk("t5_mis_rdata", rdata, 0);
    step();
    // reset one cycle after a read grant drops the read
    set(2, 32'h80020010, 0, 0, 2'b10);
    @(negedge clk);
    chk("t6_gnt", gnt[2], 1);
    step();
    req[2] = 0;
    rst_n = 0;
    loader_done = 0;
    @(negedge clk);
    chk("t6_rst_rv", rv[2], 0);
    chk("t6_rst_addr", mem_address, 0);
    step();
    step();
    rst_n = 1;
    set(1, 32'h80020020, 0, 0, 2'b10);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_no_rv", rv[2], 0);
      chk("t6_boot_p1", gnt[1], 0);
      step();
    end
    set(0, 32'h80020024, 32'h12345678, 1, 2'b10);
    @(negedge clk);
    chk("t6_boot_p0", gnt[0], 1);
    step();
    req = 0;
    // randomized boot traffic, then randomized run traffic
    en = 3'b011;
    rnd_run(300);
    req[0] = 0;
    req[2] = 0;
    loader_done = 1;
    en = 3'b111;
    rnd_run(3000);
    req = 0;
    repeat (L + 3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
